hsv_color_match_stream: RTL

Streaming, pipelined successor to the single-colour HSV binariser in the colour-detect IP. Compares each AXI4-Stream HSV pixel against NUM_COLORS programmable reference colours. Uses weighted per-channel distances and programmable thresholds, with optional circular hue distance. Emits a per-colour match mask plus sideband, and sits between the RGB-to-HSV converter and the centroid/tracking logic.

---
 rtl/hsv_color_match_stream.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/hsv_color_match_stream.sv
// Streaming HSV matcher: pixel vs NUM_COLORS references, 3-stage pipeline (distance, weighted compare, mask).
// Optional per-frame match counter is built when HSV_MATCH_COUNT_EN is defined.
module hsv_color_match_stream #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_COLORS = 2,
   parameter int unsigned H_SHIFT    = 1,
   parameter int unsigned S_SHIFT    = 2,
   parameter int unsigned V_SHIFT    = 2,
   parameter int unsigned HUE_WRAP   = 1,
   parameter int unsigned COUNT_W    = 24
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [3*DATA_W-1:0]            s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tuser,
   input  logic                           s_axis_tlast,
   input  logic [NUM_COLORS*3*DATA_W-1:0] cfg_hsv,
   input  logic [NUM_COLORS-1:0]          cfg_enable,
   input  logic [DATA_W-1:0]              cfg_h_thr,
   input  logic [DATA_W-1:0]              cfg_s_thr,
   input  logic [DATA_W-1:0]              cfg_v_thr,
   input  logic [DATA_W+1:0]              cfg_sum_thr,
   output logic [NUM_COLORS-1:0]          m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tuser,
   output logic                           m_axis_tlast,
   output logic                           match_any
`ifdef HSV_MATCH_COUNT_EN
   ,
   output logic [COUNT_W-1:0]             match_count,
   output logic                           match_count_valid
`endif
);

   localparam int unsigned PW = 3*DATA_W;
   localparam int unsigned SW = DATA_W+2;

   function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   // Tie at 2^(DATA_W-1) keeps the direct distance, so the result never exceeds half the circle.
   function automatic logic [DATA_W-1:0] hue_dist(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W:0] d;
      logic [DATA_W:0] alt;
      d   = {1'b0, abs_diff(a, b)};
      alt = {1'b1, {DATA_W{1'b0}}} - d;
      if ((HUE_WRAP != 0) && (alt < d)) return DATA_W'(alt);
      return DATA_W'(d);
   endfunction

   logic                          adv, s_acc, sof_acc;
   logic [NUM_COLORS*PW-1:0]      ref_hsv;
   logic [NUM_COLORS*PW-1:0]      act_hsv_q, act_hsv_d;
   logic [NUM_COLORS-1:0]         act_en_q, act_en_d;
   logic [DATA_W-1:0]             act_h_thr_q, act_h_thr_d, act_s_thr_q, act_s_thr_d;
   logic [DATA_W-1:0]             act_v_thr_q, act_v_thr_d;
   logic [SW-1:0]                 act_sum_thr_q, act_sum_thr_d;

   logic                          v1_q, v1_d, u1_q, u1_d, l1_q, l1_d;
   logic [NUM_COLORS-1:0][DATA_W-1:0] dh1_q, dh1_d, ds1_q, ds1_d, dv1_q, dv1_d;

   logic                          v2_q, v2_d, u2_q, u2_d, l2_q, l2_d;
   logic [NUM_COLORS-1:0]         hok2_q, hok2_d, sok2_q, sok2_d, vok2_q, vok2_d;
   logic [NUM_COLORS-1:0]         sumok2_q, sumok2_d, en2_q, en2_d;

   logic                          v3_q, v3_d, u3_q, u3_d, l3_q, l3_d;
   logic [NUM_COLORS-1:0]         mask3_q, mask3_d;

   logic [DATA_W-1:0]             hw, sw, vw;
   logic [SW-1:0]                 sum;

   always_comb begin
      adv     = !v3_q || m_axis_tready;
      s_acc   = s_axis_tvalid && adv;
      sof_acc = s_acc && s_axis_tuser;

      act_hsv_d     = act_hsv_q;
      act_en_d      = act_en_q;
      act_h_thr_d   = act_h_thr_q;
      act_s_thr_d   = act_s_thr_q;
      act_v_thr_d   = act_v_thr_q;
      act_sum_thr_d = act_sum_thr_q;
      if (sof_acc) begin
         act_hsv_d     = cfg_hsv;
         act_en_d      = cfg_enable;
         act_h_thr_d   = cfg_h_thr;
         act_s_thr_d   = cfg_s_thr;
         act_v_thr_d   = cfg_v_thr;
         act_sum_thr_d = cfg_sum_thr;
      end
      // The SOF beat sees the incoming references; later stages read the shadow registers after they load.
      ref_hsv = sof_acc ? cfg_hsv : act_hsv_q;

      v1_d = v1_q;  u1_d = u1_q;  l1_d = l1_q;
      dh1_d = dh1_q;  ds1_d = ds1_q;  dv1_d = dv1_q;
      v2_d = v2_q;  u2_d = u2_q;  l2_d = l2_q;
      hok2_d = hok2_q;  sok2_d = sok2_q;  vok2_d = vok2_q;  sumok2_d = sumok2_q;  en2_d = en2_q;
      v3_d = v3_q;  u3_d = u3_q;  l3_d = l3_q;  mask3_d = mask3_q;
      hw = '0;  sw = '0;  vw = '0;  sum = '0;

      if (adv) begin
         v1_d = s_axis_tvalid;
         u1_d = s_axis_tuser;
         l1_d = s_axis_tlast;
         v2_d = v1_q;
         u2_d = u1_q;
         l2_d = l1_q;
         v3_d = v2_q;
         u3_d = u2_q;
         l3_d = l2_q;
         for (int unsigned k = 0; k < NUM_COLORS; k++) begin
            dh1_d[k] = hue_dist(s_axis_tdata[2*DATA_W +: DATA_W], ref_hsv[k*PW + 2*DATA_W +: DATA_W]);
            ds1_d[k] = abs_diff(s_axis_tdata[DATA_W +: DATA_W], ref_hsv[k*PW + DATA_W +: DATA_W]);
            dv1_d[k] = abs_diff(s_axis_tdata[0 +: DATA_W], ref_hsv[k*PW +: DATA_W]);

            hw  = dh1_q[k] >> H_SHIFT;
            sw  = ds1_q[k] >> S_SHIFT;
            vw  = dv1_q[k] >> V_SHIFT;
            sum = SW'(hw) + SW'(sw) + SW'(vw);
            hok2_d[k]   = hw <= act_h_thr_q;
            sok2_d[k]   = sw <= act_s_thr_q;
            vok2_d[k]   = vw <= act_v_thr_q;
            sumok2_d[k] = sum <= act_sum_thr_q;
            en2_d[k]    = act_en_q[k];

            mask3_d[k] = v2_q && en2_q[k] && hok2_q[k] && sok2_q[k] && vok2_q[k] && sumok2_q[k];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         act_hsv_q <= '0;  act_en_q <= '0;
         act_h_thr_q <= '0;  act_s_thr_q <= '0;  act_v_thr_q <= '0;  act_sum_thr_q <= '0;
         v1_q <= 1'b0;  u1_q <= 1'b0;  l1_q <= 1'b0;
         dh1_q <= '0;  ds1_q <= '0;  dv1_q <= '0;
         v2_q <= 1'b0;  u2_q <= 1'b0;  l2_q <= 1'b0;
         hok2_q <= '0;  sok2_q <= '0;  vok2_q <= '0;  sumok2_q <= '0;  en2_q <= '0;
         v3_q <= 1'b0;  u3_q <= 1'b0;  l3_q <= 1'b0;  mask3_q <= '0;
      end else begin
         act_hsv_q <= act_hsv_d;  act_en_q <= act_en_d;
         act_h_thr_q <= act_h_thr_d;  act_s_thr_q <= act_s_thr_d;
         act_v_thr_q <= act_v_thr_d;  act_sum_thr_q <= act_sum_thr_d;
         v1_q <= v1_d;  u1_q <= u1_d;  l1_q <= l1_d;
         dh1_q <= dh1_d;  ds1_q <= ds1_d;  dv1_q <= dv1_d;
         v2_q <= v2_d;  u2_q <= u2_d;  l2_q <= l2_d;
         hok2_q <= hok2_d;  sok2_q <= sok2_d;  vok2_q <= vok2_d;  sumok2_q <= sumok2_d;  en2_q <= en2_d;
         v3_q <= v3_d;  u3_q <= u3_d;  l3_q <= l3_d;  mask3_q <= mask3_d;
      end
   end

   assign s_axis_tready = adv;
   assign m_axis_tvalid = v3_q;
   assign m_axis_tdata  = mask3_q;
   assign m_axis_tuser  = u3_q;
   assign m_axis_tlast  = l3_q;
   assign match_any     = v3_q && (|mask3_q);

`ifdef HSV_MATCH_COUNT_EN
   logic               xfer;
   logic [COUNT_W-1:0] cnt_q, cnt_d, match_count_q, match_count_d;
   logic               match_count_valid_q, match_count_valid_d;

   always_comb begin
      xfer                = v3_q && m_axis_tready;
      cnt_d               = cnt_q;
      match_count_d       = match_count_q;
      match_count_valid_d = 1'b0;
      if (xfer && u3_q) begin
         match_count_d       = cnt_q;
         match_count_valid_d = 1'b1;
         cnt_d               = COUNT_W'(match_any);
      end else if (xfer && match_any && (cnt_q != '1)) begin
         cnt_d = cnt_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q               <= '0;
         match_count_q       <= '0;
         match_count_valid_q <= 1'b0;
      end else begin
         cnt_q               <= cnt_d;
         match_count_q       <= match_count_d;
         match_count_valid_q <= match_count_valid_d;
      end
   end

   assign match_count       = match_count_q;
   assign match_count_valid = match_count_valid_q;
`else
   logic unused_count_w;
   assign unused_count_w = (COUNT_W != 0);
`endif

endmodule
